// File: rtl/lenet_pkg.sv
// lenet_pkg -- constants and types shared by the LeNet F6 fully-connected layer.
//   F6_N_IN / F6_N_OUT : C5 inputs per neuron / number of F6 neurons
//   DATA_W             : activation, weight and result width (signed)
//   ACC_W              : accumulator width (signed)
//   ADDR_W             : C5 / weight-ROM address and neuron index width
//   F6_SHIFT           : requantisation right shift
//   f6_state_e         : layer FSM states
package lenet_pkg;

  localparam int F6_N_IN  = 120;
  localparam int F6_N_OUT = 84;
  localparam int DATA_W   = 8;
  localparam int ACC_W    = 24;
  localparam int ADDR_W   = 7;
  localparam int F6_SHIFT = 7;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DRAIN = 3'd2,
    S_OUT   = 3'd3,
    S_DONE  = 3'd4
  } f6_state_e;

endpackage

// File: rtl/f6_fc_layer_if.sv
// f6_fc_layer_if -- control, memory-read and result-stream signals of the F6 layer.
//   start/busy/done        : pass control
//   c5_raddr/c5_rdata      : C5 activation read port (1-cycle read latency)
//   w6_raddr/w6_rdata      : weight-ROM row read port, N_OUT packed signed bytes
//   f6_valid/f6_ready      : result stream handshake
//   f6_idx/f6_data         : result neuron index and requantised value
//   dbg_state              : current FSM state, for observation only
// Handshake: a result transfers on every rising edge where f6_valid and
// f6_ready are both high; while f6_valid is high and f6_ready is low the
// producer holds f6_idx/f6_data unchanged, and f6_valid never drops before
// the transfer.
// modport master = the layer, modport slave = memories + downstream consumer.
interface f6_fc_layer_if
  import lenet_pkg::*;
#(
  parameter int N_OUT = F6_N_OUT
);
  logic                  start;
  logic                  busy;
  logic                  done;
  logic [ADDR_W-1:0]     c5_raddr;
  logic [DATA_W-1:0]     c5_rdata;
  logic [ADDR_W-1:0]     w6_raddr;
  logic [N_OUT*8-1:0]    w6_rdata;
  logic                  f6_valid;
  logic                  f6_ready;
  logic [ADDR_W-1:0]     f6_idx;
  logic [DATA_W-1:0]     f6_data;
  logic [2:0]            dbg_state;

  modport master (
    input  start, c5_rdata, w6_rdata, f6_ready,
    output busy, done, c5_raddr, w6_raddr, f6_valid, f6_idx, f6_data, dbg_state
  );

  modport slave (
    output start, c5_rdata, w6_rdata, f6_ready,
    input  busy, done, c5_raddr, w6_raddr, f6_valid, f6_idx, f6_data, dbg_state
  );
endinterface

// File: rtl/f6_pe.sv
// f6_pe -- one F6 neuron lane: a clearable signed multiply-accumulate register.
//   clk, rst : clock, asynchronous active-high reset (clears the accumulator)
//   clr_i    : synchronous clear, takes priority over en_i
//   en_i     : accumulate a_i * b_i this cycle
//   a_i, b_i : signed 8-bit activation and weight
//   acc_o    : signed accumulator value
module f6_pe
  import lenet_pkg::*;
#(
  parameter int ACCW = ACC_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr_i,
  input  logic                   en_i,
  input  logic signed [7:0]      a_i,
  input  logic signed [7:0]      b_i,
  output logic signed [ACCW-1:0] acc_o
);

  logic signed [15:0]     prod;
  logic signed [ACCW-1:0] acc_q, acc_d;

  // Both operands signed, so this is a full signed 8x8 product.
  assign prod = a_i * b_i;

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + ACCW'(prod);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/f6_fc_layer.sv
// f6_fc_layer -- LeNet F6 fully-connected layer: N_OUT parallel MAC lanes
// stream N_IN C5 activations against one weight-ROM row per cycle, then the
// N_OUT requantised results are emitted one per valid/ready transfer.
//   clk, rst : clock, asynchronous active-high reset (abandons any pass)
//   bus      : f6_fc_layer_if.master (start/busy/done, C5 and weight read
//              ports, result stream, dbg_state)
// Build option: define F6_RELU_EN to clamp negative results to 0 after
// saturation; by default the signed saturated result is output.
module f6_fc_layer
  import lenet_pkg::*;
#(
  parameter int N_IN  = F6_N_IN,
  parameter int N_OUT = F6_N_OUT,
  parameter int ACCW  = ACC_W,
  parameter int SHIFT = F6_SHIFT
) (
  input  logic              clk,
  input  logic              rst,
  f6_fc_layer_if.master     bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_IN - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(N_OUT - 1);
  localparam logic signed [ACCW-1:0] SAT_HI = ACCW'(127);
  localparam logic signed [ACCW-1:0] SAT_LO = ACCW'(-128);

  f6_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              mac_en_q;
  logic              clr;

  logic signed [ACCW-1:0] acc [N_OUT];
  logic signed [ACCW-1:0] sel_acc;
  logic signed [ACCW-1:0] shifted;
  logic signed [7:0]      res;

  // ---------------------------------------------------------------- FSM
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    clr     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_LOAD;
          addr_d  = '0;
          idx_d   = '0;
          clr     = 1'b1;
        end
      end
      S_LOAD: begin
        // The address parks on the last row so nothing wraps back to 0.
        if (addr_q == LAST_ADDR) begin
          state_d = S_DRAIN;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_DRAIN: begin
        state_d = S_OUT;
        idx_d   = '0;
      end
      S_OUT: begin
        if (bus.f6_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // mac_en_q trails LOAD by one cycle to line up with the 1-cycle read
  // latency: row k's data arrives the cycle after address k, and the final
  // row is accumulated during DRAIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      idx_q    <= '0;
      mac_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      idx_q    <= idx_d;
      mac_en_q <= (state_q == S_LOAD);
    end
  end

  // ---------------------------------------------------------------- lanes
  for (genvar j = 0; j < N_OUT; j++) begin : g_lane
    f6_pe #(.ACCW(ACCW)) u_pe (
      .clk   (clk),
      .rst   (rst),
      .clr_i (clr),
      .en_i  (mac_en_q),
      .a_i   (bus.c5_rdata),
      .b_i   (bus.w6_rdata[8*j +: 8]),
      .acc_o (acc[j])
    );
  end

  // ---------------------------------------------------------------- requantise
  // Arithmetic shift floors toward -inf; saturate, then optional ReLU.
  always_comb begin
    sel_acc = acc[idx_q];
    shifted = sel_acc >>> SHIFT;
    if (shifted > SAT_HI) begin
      res = 8'sd127;
    end else if (shifted < SAT_LO) begin
      res = -8'sd128;
    end else begin
      res = shifted[7:0];
    end
`ifdef F6_RELU_EN
    if (res < 0) begin
      res = 8'sd0;
    end
`endif
  end

  // ---------------------------------------------------------------- outputs
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.f6_valid  = (state_q == S_OUT);
  assign bus.c5_raddr  = addr_q;
  assign bus.w6_raddr  = addr_q;
  assign bus.f6_idx    = idx_q;
  // Data is forced to 0 outside OUT so reset and idle present a clean bus.
  assign bus.f6_data   = (state_q == S_OUT) ? res : '0;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_f6_fc_layer.sv
`timescale 1ns/1ps
module tb_f6_fc_layer;
  import lenet_pkg::*;

  localparam int N_IN    = F6_N_IN;
  localparam int N_OUT   = F6_N_OUT;
  localparam int SHIFT   = F6_SHIFT;
  localparam int TIMEOUT = 2000;

  // ---------------------------------------------------------------- clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  f6_fc_layer_if #(.N_OUT(N_OUT)) bus ();

  f6_fc_layer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // ---------------------------------------------------------------- memories
  int                 c5_arr [N_IN];
  int                 w_arr  [N_IN][N_OUT];
  logic [7:0]         c5_mem [N_IN];
  logic [N_OUT*8-1:0] w_mem  [N_IN];

  // Synchronous-read memories, one cycle of latency.
  always @(posedge clk) begin
    bus.c5_rdata <= c5_mem[bus.c5_raddr];
    bus.w6_rdata <= w_mem[bus.w6_raddr];
  end

  // ---------------------------------------------------------------- scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [14:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // mode 0: inputs 2 / weights +1, 1: 127 / -1, 2: 64 / 64, else random
  task automatic load_data(input int mode);
    for (int k = 0; k < N_IN; k++) begin
      case (mode)
        0:       c5_arr[k] = 2;
        1:       c5_arr[k] = 127;
        2:       c5_arr[k] = 64;
        default: c5_arr[k] = int'($urandom_range(0, 255)) - 128;
      endcase
      c5_mem[k] = 8'(c5_arr[k]);
      for (int j = 0; j < N_OUT; j++) begin
        case (mode)
          0:       w_arr[k][j] = 1;
          1:       w_arr[k][j] = -1;
          2:       w_arr[k][j] = 64;
          default: w_arr[k][j] = int'($urandom_range(0, 255)) - 128;
        endcase
        w_mem[k][8*j +: 8] = 8'(w_arr[k][j]);
      end
    end
  endtask

  // Reference: dot product, floor division by 2^SHIFT, clamp to int8, optional ReLU.
  task automatic build_expect();
    int s, q, div, rem;
    div = 1 << SHIFT;
    exp_q.delete();
    for (int j = 0; j < N_OUT; j++) begin
      s = 0;
      for (int k = 0; k < N_IN; k++) s += c5_arr[k] * w_arr[k][j];
      rem = ((s % div) + div) % div;
      q = (s - rem) / div;
      if (q > 127) q = 127;
      if (q < -128) q = -128;
`ifdef F6_RELU_EN
      if (q < 0) q = 0;
`endif
      exp_q.push_back({7'(j), 8'(q)});
    end
  endtask

  // ---------------------------------------------------------------- driver
  // ready_mode 0: always ready, 1: random ready, 2: ready low 3 cycles at idx 10
  task automatic run_pass(input int ready_mode, input bit repulse, input bit chk_done_lat,
                          output logic [7:0] first_data);
    int cyc, first_cyc, done_cyc, n_xfer, stall, busy_bad, addr_bad;
    cyc = 0; first_cyc = -1; done_cyc = -1; n_xfer = 0; stall = 0;
    busy_bad = 0; addr_bad = 0; first_data = '0;
    @(negedge clk);
    bus.start = 1'b1;
    while (done_cyc < 0 && cyc < TIMEOUT) begin
      @(negedge clk);
      cyc++;
      bus.start = repulse && (cyc == 40 || cyc == N_IN + 10);
      case (ready_mode)
        0: bus.f6_ready = 1'b1;
        1: bus.f6_ready = ($urandom_range(0, 3) != 0);
        default: begin
          bus.f6_ready = !(bus.f6_valid && bus.f6_idx == 7'd10 && stall < 3);
          if (!bus.f6_ready) stall++;
        end
      endcase
      if (bus.c5_raddr !== bus.w6_raddr) addr_bad++;
      if (cyc <= N_IN && bus.c5_raddr !== 7'(cyc - 1)) addr_bad++;
      if (!bus.busy) busy_bad++;
      if (bus.f6_valid && first_cyc < 0) first_cyc = cyc;
      if (bus.f6_valid && bus.f6_ready) begin
        if (exp_q.size() == 0) check("extra_xfer", 32'(n_xfer), 32'(N_OUT - 1));
        else check("xfer", 32'({bus.f6_idx, bus.f6_data}), 32'(exp_q.pop_front()));
        if (n_xfer == 0) first_data = bus.f6_data;
        n_xfer++;
      end else if (bus.f6_valid && exp_q.size() > 0) begin
        check("held", 32'({bus.f6_idx, bus.f6_data}), 32'(exp_q[0]));
      end
      if (bus.done) done_cyc = cyc;
    end
    check("done_seen", 32'(done_cyc >= 0), 32'd1);
    check("first_valid_lat", 32'(first_cyc), 32'(N_IN + 2));
    if (chk_done_lat) check("done_lat", 32'(done_cyc), 32'(N_IN + N_OUT + 2));
    check("n_xfer", 32'(n_xfer), 32'(N_OUT));
    if (ready_mode == 2) check("stall_cycles", 32'(stall), 32'd3);
    check("addr_track", 32'(addr_bad), 32'd0);
    check("busy_span", 32'(busy_bad), 32'd0);
    @(negedge clk);
    bus.f6_ready = 1'b0;
    check("done_pulse", 32'({bus.done, bus.busy, bus.f6_valid}), 32'd0);
  endtask

  function automatic logic [31:0] out_vec();
    return 32'({bus.busy, bus.done, bus.f6_valid, bus.c5_raddr, bus.w6_raddr,
                bus.f6_idx, bus.f6_data});
  endfunction

  task automatic reset_mid_load();
    int bad;
    bad = 0;
    @(negedge clk);
    bus.start = 1'b1;
    repeat (51) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    check("addr_k50", 32'(bus.c5_raddr), 32'd50);
    rst = 1'b1;
    #1;
    check("rst_async_outs", out_vec(), 32'd0);
    @(negedge clk);
    check("rst_held_outs", out_vec(), 32'd0);
    check("rst_state", 32'(bus.dbg_state), 32'd0);
    rst = 1'b0;
    repeat (N_IN + N_OUT + 10) begin
      @(negedge clk);
      if (bus.done || bus.busy || bus.f6_valid) bad++;
    end
    check("no_done_after_rst", 32'(bad), 32'd0);
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    logic [7:0] fd;
    bus.start    = 1'b0;
    bus.f6_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs", out_vec(), 32'd0);
    check("reset_state", 32'(bus.dbg_state), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    load_data(0); build_expect();
    run_pass(0, 1'b0, 1'b1, fd);
    check("all2_data", 32'(fd), 32'd1);

    load_data(1); build_expect();
    run_pass(0, 1'b0, 1'b1, fd);
`ifdef F6_RELU_EN
    check("neg_relu_data", 32'(fd), 32'h00);
`else
    check("neg_data", 32'(fd), 32'h88);
`endif

    load_data(2); build_expect();
    run_pass(0, 1'b0, 1'b1, fd);
    check("sat_data", 32'(fd), 32'h7f);

    load_data(3); build_expect();
    run_pass(2, 1'b0, 1'b0, fd);

    load_data(3); build_expect();
    run_pass(0, 1'b1, 1'b1, fd);

    reset_mid_load();

    load_data(3); build_expect();
    run_pass(1, 1'b0, 1'b0, fd);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
